// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: bus widths, reset vector, PC step and the
// record stored per fetched instruction.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 16'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned; a branch target's bit 0 is dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions with flush. The head record is
// forced to zero while the queue is empty so decode never sees stale data.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  // Flush wins over both push and pop; a pop on an empty queue is dropped.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (cnt != 2'd0);

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  assign head_valid = (cnt != 2'd0);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign count      = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues it to the combinational instruction
// memory, queues returned words for decode and handles branch redirects.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               misalign
);

  logic [ADDR_W-1:0] pc_p0;
  logic              misalign_p1;
  logic              pop;
  logic              push;
  logic [1:0]        count;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  // Memory address comes straight from the PC register.
  assign imem_addr = pc_p0;

  // A slot frees up in the same cycle the head is taken, so a full queue can
  // still accept a word when decode pops. Redirect cycles never push: the
  // word returned for the old PC belongs to the killed path.
  assign pop      = if_valid & if_ready;
  assign push     = fetch_en & ~redirect & ((count < 2'd2) | pop);
  assign wr_entry = '{pc: pc_p0, instr: imem_data};

  // PC register: redirect has priority, otherwise advance on every push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc_p0 <= RESET_PC;
    else if (redirect) pc_p0 <= align_pc(redirect_pc);
    else if (push)     pc_p0 <= pc_p0 + PC_STEP;
  end

  // One-cycle flag for a redirect whose target was odd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_p1 <= 1'b0;
    else     misalign_p1 <= redirect & redirect_pc[0];
  end

  assign misalign = misalign_p1;

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .head       (head),
    .head_valid (if_valid),
    .count      (count)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based reference model of the fetch rules.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        misalign;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: queued PCs, next fetch PC, misalign flag.
  logic [15:0] mq[$];
  logic [15:0] mpc;
  logic        mis;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .misalign    (misalign)
  );

  // Combinational instruction memory: word = address ^ A5A5.
  assign imem_data = imem_addr ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [49:0] model_out();
    logic        v;
    logic [15:0] hp;
    logic [15:0] hi;
    v  = (mq.size() > 0);
    hp = v ? mq[0] : 16'h0000;
    hi = v ? (hp ^ 16'hA5A5) : 16'h0000;
    return {v, hp, hi, mpc, mis};
  endfunction

  task automatic reset_model();
    mq.delete();
    mpc = 16'h0000;
    mis = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    fetch_en = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    #1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then wait past the edge.
  task automatic cycle(input logic fen, input logic rdy, input logic rd, input logic [15:0] rpc);
    int   sz;
    logic p;
    fetch_en = fen; if_ready = rdy; redirect = rd; redirect_pc = rpc;
    sz = mq.size();
    p  = (sz > 0) && rdy;
    if (rd) begin
      mq.delete();
      mpc = rpc & 16'hFFFE;
      mis = rpc[0];
    end else begin
      if (p) void'(mq.pop_front());
      if (fen && (sz < 2 || p)) begin
        mq.push_back(mpc);
        mpc = mpc + 16'd2;
      end
      mis = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    #1;
    reset_model();
    n_checks++;
    if ({if_valid, if_pc, if_instr, imem_addr, misalign} !== 50'h0)
      $display("FAIL reset: got %h want 0", {if_valid, if_pc, if_instr, imem_addr, misalign});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [49:0] got;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL stream[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
      n_checks++;
      if (if_pc !== 16'(2 * i)) $display("FAIL stream_pc[%0d]: got %h want %h", i, if_pc, 16'(2 * i));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [49:0] got;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL stall[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
    end
    n_checks++;
    if ({imem_addr, if_pc, if_valid} !== {16'h0004, 16'h0000, 1'b1})
      $display("FAIL full_hold: got addr %h pc %h v %b want 0004 0000 1", imem_addr, if_pc, if_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL drain[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    logic [49:0] got;
    apply_reset();
    cycle(1'b1, 1'b0, 1'b1, 16'h0010);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({if_valid, if_pc, imem_addr} !== {1'b1, 16'h0010, 16'h0014})
      $display("FAIL redir_setup: got v %b pc %h addr %h want 1 0010 0014", if_valid, if_pc, imem_addr);
    else n_pass++;
    cycle(1'b1, 1'b1, 1'b1, 16'h0040);
    n_checks++;
    if ({if_valid, imem_addr, misalign} !== {1'b0, 16'h0040, 1'b0})
      $display("FAIL redir_bubble: got v %b addr %h mis %b want 0 0040 0", if_valid, imem_addr, misalign);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL redir[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
      n_checks++;
      if (if_pc !== 16'(16'h0040 + 2 * i)) $display("FAIL redir_pc[%0d]: got %h want %h", i, if_pc, 16'(16'h0040 + 2 * i));
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    cycle(1'b1, 1'b1, 1'b1, 16'h0031);
    n_checks++;
    if ({misalign, imem_addr, if_valid} !== {1'b1, 16'h0030, 1'b0})
      $display("FAIL misalign_set: got mis %b addr %h v %b want 1 0030 0", misalign, imem_addr, if_valid);
    else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({misalign, if_pc, if_valid} !== {1'b0, 16'h0030, 1'b1})
      $display("FAIL misalign_clr: got mis %b pc %h v %b want 0 0030 1", misalign, if_pc, if_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFE);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'hFFFE, 16'hFFFE ^ 16'hA5A5})
      $display("FAIL wrap_top: got v %b pc %h instr %h want 1 fffe %h", if_valid, if_pc, if_instr, 16'hFFFE ^ 16'hA5A5);
    else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 16'h0000})
      $display("FAIL wrap_zero: got v %b pc %h want 1 0000", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [49:0] got;
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({if_valid, imem_addr, if_pc} !== {1'b0, 16'h0000, 16'h0000})
      $display("FAIL async_rst: got v %b addr %h pc %h want 0 0000 0000", if_valid, imem_addr, if_pc);
    else n_pass++;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL resume[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [49:0] got;
    logic        fen;
    logic        rdy;
    logic        rd;
    logic [15:0] rpc;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      fen = ($urandom_range(0, 99) < 80);
      rdy = ($urandom_range(0, 99) < 65);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = 16'($urandom_range(0, 65535));
      cycle(fen, rdy, rd, rpc);
      got = {if_valid, if_pc, if_instr, imem_addr, misalign};
      n_checks++;
      if (got !== model_out()) $display("FAIL random[%0d]: got %h want %h", i, got, model_out());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    reset_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC-generating initiator that drives the instruction memory address and consumes the returned instruction word.
- Sits between the combinational `instr_mem` (address in, instruction out, same cycle) and the decode stage.
- Buffers fetched words in a 2-entry queue with a valid/ready handshake toward decode.
- Supports branch redirect with flush, and fetch enable.

Parameters:
- ADDR_W, 16, width of PC and memory address (byte address).
- INSTR_W, 16, instruction width; PC advances by 2 bytes per instruction.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  1 = fetch new words; 0 = hold PC, queue drains.
- imem_addr  output  ADDR_W  address to instruction memory; equals the PC register.
- imem_data  input  INSTR_W  instruction from memory; valid in the same cycle as imem_addr.
- redirect  input  1  branch/jump taken; single-cycle pulse or level.
- redirect_pc  input  ADDR_W  new PC target.
- if_valid  output  1  head of queue holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  INSTR_W  head instruction word.
- if_pc  output  ADDR_W  address the head instruction was fetched from.
- misalign  output  1  registered one-cycle pulse: the accepted redirect_pc had bit 0 set.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; queue empty (count=0, rd/wr pointers 0).
  - if_valid=0, misalign=0.
  - if_instr and if_pc read as 0 while empty.
- imem_addr = pc, driven from the register with no combinational path from inputs.
- pop = if_valid & if_ready.
- push = fetch_en & ~redirect & (count<2 | pop).
- On push:
  - Entry {pc, imem_data} is written at wr_ptr.
  - pc <= pc+2, truncated to ADDR_W; it wraps from max to 0 with no error.
- On pop: rd_ptr advances.
- count update: count += push - pop.
- Redirect has highest priority:
  - Queue flushed: count=0, pointers reset.
  - The same-cycle pop is ignored; decode must treat a redirect cycle as a kill.
  - pc <= {redirect_pc[ADDR_W-1:1],1'b0}.
  - misalign <= redirect_pc[0] on the next edge.
  - The word on imem_data in that cycle is discarded.
- Latency:
  - Word at address A is presented on if_valid 1 cycle after pc==A with push.
  - Redirect to T: if_pc==T with if_valid=1 two edges after the redirect edge (one edge to load pc, one to push). One bubble cycle.
- Full (count=2):
  - Without pop, no push; pc holds, imem_addr stable.
  - With pop, push proceeds (simultaneous push/pop, count stays 2).
- Empty: if_valid=0, and if_ready is ignored.
- fetch_en=0: pc holds; existing entries remain poppable.
- Throughput: 1 instruction/cycle sustained when if_ready=1.
- Reset asserted mid-operation: all state cleared immediately, regardless of in-flight handshake.
- The misalign pulse is cleared to 0 on every cycle without a misaligned redirect.

Decomposition:
- Shared package `cpu_pkg`: ADDR_W, INSTR_W, RESET_PC, PC_STEP=2, and a fetch-entry record {pc, instr}.
- One natural sub-module, `fetch_queue`:
  - 2-entry synchronous FIFO with flush, push/pop, count, head outputs.
- instr_fetch keeps the PC register, push/redirect logic, and the misalign flag.

Test Plan:
1. Reset then fetch_en=1, if_ready=1, memory returns word=addr^16'hA5A5 -> if_pc sequence 0x0000, 0x0002, 0x0004… one per cycle, if_instr matching; first if_valid one edge after rst release.
2. if_ready=0 for 5 cycles from reset -> count reaches 2, if_pc=0x0000 held, imem_addr stuck at 0x0004; then if_ready=1 -> 0x0000, 0x0002, 0x0004 delivered with no gaps or duplicates.
3. redirect=1, redirect_pc=0x0040 while queue holds 0x0010/0x0012 -> queue flushed, one bubble, next if_pc=0x0040, then 0x0042; misalign stays 0.
4. redirect_pc=0x0031 -> pc loads 0x0030, misalign pulses 1 for exactly one cycle, next if_pc=0x0030.
5. Redirect to 0xFFFE with if_ready=1 -> if_pc 0xFFFE then 0x0000 (wrap).
6. Assert rst asynchronously mid-stream with count=2 -> if_valid=0 and imem_addr=RESET_PC before the next clock edge; fetch resumes from 0x0000 after release.
